// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the EX stage and the iterative multiply/divide unit.
// The master drives operations and MT writes; the slave returns HI/LO and status.
interface muldiv_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              cancel;
    logic [1:0]        mt_we;
    logic [DATA_W-1:0] mt_data;
    logic              busy;
    logic              done;
    logic              div_by_zero;
    logic [DATA_W-1:0] HI;
    logic [DATA_W-1:0] LO;

    modport master (
        output start, op, A, B, cancel, mt_we, mt_data,
        input  busy, done, div_by_zero, HI, LO
    );

    modport slave (
        input  start, op, A, B, cancel, mt_we, mt_data,
        output busy, done, div_by_zero, HI, LO
    );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, MTHI/MTLO and flush.
// One iteration per clock for DATA_W clocks, then a sign-fixup clock that writes HI/LO.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_is_div;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_b_zero;
    logic [DATA_W-1:0]   r_opnd;
    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_done;
    logic                r_dbz;

    logic                w_accept;
    logic                w_fix_we;
    logic [DATA_W-1:0]   w_abs_a;
    logic [DATA_W-1:0]   w_abs_b;
    logic [DATA_W:0]     w_mul_sum;
    logic [2*DATA_W-1:0] w_mul_next;
    logic [DATA_W:0]     w_rem_sh;
    logic [DATA_W+1:0]   w_diff;
    logic [2*DATA_W-1:0] w_div_next;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quot;
    logic [DATA_W-1:0]   w_rem;
    logic [DATA_W-1:0]   w_fix_hi;
    logic [DATA_W-1:0]   w_fix_lo;

    assign w_accept = (r_state == IDLE) && bus.start && !bus.cancel;
    assign w_abs_a  = (bus.op[0] && bus.A[DATA_W-1]) ? -bus.A : bus.A;
    assign w_abs_b  = (bus.op[0] && bus.B[DATA_W-1]) ? -bus.B : bus.B;

    // Multiply: r_opnd is |A|, low half of r_acc starts as |B| and is shifted out LSB first.
    assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};

    // Divide: r_opnd is |B|, r_acc holds remainder:quotient with |A| starting in the low half.
    assign w_rem_sh   = r_acc[2*DATA_W-1:DATA_W-1];
    assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_opnd};
    assign w_div_next = w_diff[DATA_W+1] ? {w_rem_sh[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0}
                                         : {w_diff[DATA_W-1:0],   r_acc[DATA_W-2:0], 1'b1};

    // With a zero divisor every trial subtract succeeds, so the remainder ends as |A| and
    // the signed remainder fixup restores the original A; only LO needs forcing.
    assign w_prod   = r_neg_q ? -r_acc : r_acc;
    assign w_quot   = r_acc[DATA_W-1:0];
    assign w_rem    = r_acc[2*DATA_W-1:DATA_W];
    assign w_fix_hi = r_is_div ? (r_neg_r ? -w_rem : w_rem) : w_prod[2*DATA_W-1:DATA_W];
    assign w_fix_lo = r_is_div ? (r_b_zero ? '1 : (r_neg_q ? -w_quot : w_quot))
                               : w_prod[DATA_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_fix_we    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (bus.cancel) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_W'(DATA_W - 1)) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_state_nxt = IDLE;
                w_fix_we    = !bus.cancel;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= w_fix_we;

            if (r_state == IDLE) begin
                if (bus.mt_we[1]) begin
                    r_hi <= bus.mt_data;
                end
                if (bus.mt_we[0]) begin
                    r_lo <= bus.mt_data;
                end
            end

            if (w_accept) begin
                r_is_div <= bus.op[1];
                r_neg_q  <= bus.op[0] & (bus.A[DATA_W-1] ^ bus.B[DATA_W-1]);
                r_neg_r  <= bus.op[0] & bus.A[DATA_W-1];
                r_b_zero <= (bus.B == '0);
                r_opnd   <= bus.op[1] ? w_abs_b : w_abs_a;
                r_acc    <= {{DATA_W{1'b0}}, (bus.op[1] ? w_abs_a : w_abs_b)};
                r_cnt    <= '0;
                r_dbz    <= 1'b0;
            end

            if (r_state == CALC) begin
                r_acc <= r_is_div ? w_div_next : w_mul_next;
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_fix_we) begin
                r_hi  <= w_fix_hi;
                r_lo  <= w_fix_lo;
                r_dbz <= r_is_div & r_b_zero;
            end
        end
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.HI          = r_hi;
    assign bus.LO          = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for results/latency, hand sequences for
// MT writes, ignored start, cancel, div-by-zero clearing and mid-operation reset.
module tb_muldiv_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    muldiv_unit_if #(.DATA_W(32)) bus ();

    muldiv_unit #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges after the accept edge until done is seen (100 means it never came).
    task automatic wait_done(output int lat, output logic busy_ok);
        logic got;
        got     = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!got && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) begin
                got = 1'b1;
                if (bus.busy) busy_ok = 1'b0;
            end else if (!bus.busy) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic busy_ok);
        issue(op, a, b);
        wait_done(lat, busy_ok);
    endtask

    initial begin
        int   lat;
        logic busy_ok;
        logic saw_done;

        n_checks = 0;
        n_fail   = 0;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.A       = '0;
        bus.B       = '0;
        bus.cancel  = 1'b0;
        bus.mt_we   = 2'b00;
        bus.mt_data = '0;
        reset       = 1'b1;

        vecs[0]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{2'd0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        vecs[4]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[5]  = '{2'd2, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[6]  = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[7]  = '{2'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[9]  = '{2'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[10] = '{2'd2, 32'h00000005, 32'h0000000A, 32'h00000005, 32'h00000000, 1'b0};
        vecs[11] = '{2'd3, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
        vecs[12] = '{2'd3, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_hi",   bus.HI, 0);
        chk("reset_lo",   bus.LO, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_dbz",  bus.div_by_zero, 0);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_ok);
            chk($sformatf("v%0d_latency", i), 64'(lat), 33);
            chk($sformatf("v%0d_busy", i), busy_ok, 1);
            chk($sformatf("v%0d_hi", i), bus.HI, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), bus.LO, vecs[i].lo);
            chk($sformatf("v%0d_dbz", i), bus.div_by_zero, vecs[i].dbz);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), bus.done, 0);
        end

        // div_by_zero from the last vector holds until the next accepted start clears it.
        chk("dbz_held", bus.div_by_zero, 1);
        issue(2'd2, 32'd10, 32'd3);
        chk("dbz_clear_on_start", bus.div_by_zero, 0);
        wait_done(lat, busy_ok);
        chk("divu10_3_lo", bus.LO, 3);
        chk("divu10_3_hi", bus.HI, 1);

        // MTHI/MTLO preload, then ignored start, ignored MT while busy, and cancel.
        @(negedge clk);
        bus.mt_we = 2'b10; bus.mt_data = 32'h0000AAAA;
        @(negedge clk);
        bus.mt_we = 2'b01; bus.mt_data = 32'h00005555;
        @(negedge clk);
        bus.mt_we = 2'b00;
        chk("mt_hi", bus.HI, 32'h0000AAAA);
        chk("mt_lo", bus.LO, 32'h00005555);
        issue(2'd0, 32'd3, 32'd5);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            bus.start   = (c == 5);
            bus.A       = 32'd9;
            bus.mt_we   = (c == 7) ? 2'b11 : 2'b00;
            bus.mt_data = 32'hDEADBEEF;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.mt_we = 2'b00;
        chk("busy_before_cancel", bus.busy, 1);
        chk("mt_ignored_busy_hi", bus.HI, 32'h0000AAAA);
        bus.cancel = 1'b1;
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        chk("cancel_busy", bus.busy, 0);
        chk("cancel_hi", bus.HI, 32'h0000AAAA);
        chk("cancel_lo", bus.LO, 32'h00005555);
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        chk("cancel_no_done", saw_done, 0);

        // cancel and start together in IDLE: nothing accepted.
        @(negedge clk);
        bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 2'd0; bus.A = 32'd2; bus.B = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.cancel = 1'b0;
        chk("cancel_start_idle_busy", bus.busy, 0);

        // MT write coinciding with an accepted start: both take effect.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd0; bus.A = 32'd2; bus.B = 32'd3;
        bus.mt_we = 2'b11; bus.mt_data = 32'h00000077;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.mt_we = 2'b00;
        chk("mt_start_hi", bus.HI, 32'h00000077);
        chk("mt_start_lo", bus.LO, 32'h00000077);
        chk("mt_start_busy", bus.busy, 1);
        wait_done(lat, busy_ok);
        chk("mt_start_latency", 64'(lat), 33);
        chk("mt_start_res_hi", bus.HI, 0);
        chk("mt_start_res_lo", bus.LO, 6);

        // Reset in the middle of a DIV aborts it and clears HI/LO.
        issue(2'd3, 32'hFFFFFFF9, 32'd2);
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midreset_hi",   bus.HI, 0);
        chk("midreset_lo",   bus.LO, 0);
        chk("midreset_busy", bus.busy, 0);
        chk("midreset_done", bus.done, 0);
        run_op(2'd1, 32'hFFFFFFFD, 32'd7, lat, busy_ok);
        chk("post_reset_latency", 64'(lat), 33);
        chk("post_reset_hi", bus.HI, 32'hFFFFFFFF);
        chk("post_reset_lo", bus.LO, 32'hFFFFFFEB);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
